// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler for an 8-to-1 mux datapath: grants one requester at a
// time for a bounded burst and qualifies the mux output with valid/ready.
`timescale 1ns/1ps

module mux8_rr_scheduler #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out_valid,
    output logic       busy
);

    localparam logic [0:0]       IDLE      = 1'b0;
    localparam logic [0:0]       GRANT     = 1'b1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] count;
    logic [2:0]       winner;
    logic [2:0]       idx;
    logic             found;
    logic             transfer;
    logic             release_now;

    // First set request bit at or after ptr, wrapping modulo 8.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + i[2:0];
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign busy        = (state == GRANT);
    assign out_valid   = busy && req[sel];
    assign transfer    = out_valid && out_ready;
    // A dropped request or the last permitted beat both end the grant.
    assign release_now = busy && (!req[sel] || (transfer && (count == LAST_BEAT)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= '0;
            grant <= '0;
            ptr   <= '0;
            count <= '0;
        end else if (state == IDLE) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (found) begin
                sel   <= winner;
                grant <= 8'b1 << winner;
                count <= '0;
                state <= GRANT;
            end
        end else begin
            if (release_now) begin
                state <= IDLE;
                grant <= '0;
                count <= '0;
                ptr   <= sel + 3'd1;
            end else if (transfer) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Scoreboard bench for mux8_rr_scheduler: stimulus queues expected select per
// beat, a negedge monitor pops and compares on every valid/ready transfer.
`timescale 1ns/1ps

module tb_mux8_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    logic [2:0] exp_q[$];

    mux8_rr_scheduler #(.MAX_BURST(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input logic [2:0] s, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(s);
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        cyc();
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Steady-state rotation: grant for 4 cycles, then exactly one idle cycle.
    task automatic burst_train(input int n_cycles);
        for (int n = 0; n < n_cycles; n++) begin
            if (n > 0) cyc();
            @(negedge clk);
            check("train_busy", busy, (n != 0) && (((n - 1) % 5) != 4));
        end
    endtask

    // Monitor: every accepted beat must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {29'd0, sel}, 32'hFFFF_FFFF);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                check("beat_sel", sel, e);
                check("beat_grant", grant, 8'b1 << e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_sel", sel, 0);
        check("rst_grant", grant, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        cyc();
        rst_n = 1'b1;

        // Single requester: 1-cycle latency, 4 beats, idle gap, re-grant via wrap.
        req       = 8'h01;
        out_ready = 1'b1;
        push_beats(3'd0, 4);
        @(negedge clk);
        check("t1_idle_grant", grant, 0);
        check("t1_idle_busy", busy, 0);
        cyc();
        @(negedge clk);
        check("t1_grant", grant, 8'h01);
        check("t1_sel", sel, 0);
        check("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            check("t1_valid", out_valid, 1);
        end
        cyc();
        @(negedge clk);
        check("t1_gap_grant", grant, 0);
        check("t1_gap_valid", out_valid, 0);
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        check("t1_regrant", grant, 8'h01);
        check("t1_regrant_valid", out_valid, 1);
        cyc();
        req = '0;
        @(negedge clk);
        check("t1_drop_valid", out_valid, 0);
        check("t1_drop_busy", busy, 1);
        cyc();
        @(negedge clk);
        check("t1_release", grant, 0);

        // All requesting: 0..7 then wrap to 0.
        do_reset();
        req       = 8'hFF;
        out_ready = 1'b1;
        for (int g = 0; g < 9; g++) push_beats(3'(g % 8), 4);
        burst_train(45);
        cyc();
        req = '0;
        @(negedge clk);
        check("t2_end_idle", busy, 0);

        // Sparse requests: 2, 7, 2.
        do_reset();
        req       = 8'b1000_0100;
        out_ready = 1'b1;
        push_beats(3'd2, 4);
        push_beats(3'd7, 4);
        push_beats(3'd2, 4);
        burst_train(15);
        cyc();
        req = '0;
        @(negedge clk);
        check("t3_end_idle", busy, 0);

        // Backpressure: grant held with out_ready low, then exactly 4 beats.
        do_reset();
        req       = 8'h08;
        out_ready = 1'b0;
        @(negedge clk);
        check("t4_idle", busy, 0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", out_valid, 1);
            check("t4_hold_grant", grant, 8'h08);
            cyc();
        end
        out_ready = 1'b1;
        push_beats(3'd3, 4);
        repeat (4) begin
            @(negedge clk);
            cyc();
        end
        req = '0;
        @(negedge clk);
        check("t4_release_grant", grant, 0);
        check("t4_release_busy", busy, 0);

        // Request drop after 2 beats: early release, pointer moves to 6.
        do_reset();
        req       = 8'h20;
        out_ready = 1'b1;
        push_beats(3'd5, 2);
        @(negedge clk);
        repeat (2) begin
            cyc();
            @(negedge clk);
        end
        cyc();
        req = '0;
        @(negedge clk);
        check("t5_drop_valid", out_valid, 0);
        check("t5_drop_grant", grant, 8'h20);
        cyc();
        req       = 8'h60;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_released", grant, 0);
        cyc();
        @(negedge clk);
        check("t5_ptr_sel", sel, 6);
        check("t5_ptr_grant", grant, 8'h40);

        // Asynchronous reset mid-burst, then fresh burst of full length.
        do_reset();
        req       = 8'h10;
        out_ready = 1'b1;
        push_beats(3'd4, 2);
        @(negedge clk);
        repeat (2) begin
            cyc();
            @(negedge clk);
        end
        cyc();
        rst_n = 1'b0;
        #1;
        check("t6_async_sel", sel, 0);
        check("t6_async_grant", grant, 0);
        check("t6_async_valid", out_valid, 0);
        check("t6_async_busy", busy, 0);
        cyc();
        push_beats(3'd4, 4);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_idle", grant, 0);
        cyc();
        @(negedge clk);
        check("t6_regrant", grant, 8'h10);
        check("t6_regrant_sel", sel, 4);
        repeat (3) begin
            cyc();
            @(negedge clk);
        end
        cyc();
        req = '0;
        @(negedge clk);
        check("t6_release", grant, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
